// File: rtl/codec_cfg_sequencer_pkg.sv
// Shared definitions for the codec configuration sequencer.
// Contents:
//   - cfg_state_e      : sequencer FSM state encoding
//   - codec register address constants (LINVOL .. ACTIVE)
//   - default run-length, timeout and retry parameters
//   - cnt_width()      : width helper for saturating counters
package codec_cfg_sequencer_pkg;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_LOAD   = 3'd1,
        ST_ISSUE  = 3'd2,
        ST_WAIT   = 3'd3,
        ST_GAP    = 3'd4,
        ST_NEXT   = 3'd5,
        ST_FINISH = 3'd6,
        ST_FAIL   = 3'd7
    } cfg_state_e;

    localparam logic [6:0] LINVOL = 7'h00;
    localparam logic [6:0] RINVOL = 7'h01;
    localparam logic [6:0] LHPOUT = 7'h02;
    localparam logic [6:0] RHPOUT = 7'h03;
    localparam logic [6:0] AAPC   = 7'h04;
    localparam logic [6:0] DAPC   = 7'h05;
    localparam logic [6:0] PDC    = 7'h06;
    localparam logic [6:0] DAIF   = 7'h07;
    localparam logic [6:0] SRC    = 7'h08;
    localparam logic [6:0] ACTIVE = 7'h09;

    localparam int unsigned DEF_N_REGS    = 32'd10;
    localparam int unsigned DEF_TIMEOUT   = 32'd1023;
    localparam int unsigned DEF_MAX_RETRY = 32'd2;

    // Bits needed to hold 0..max_val; never less than one bit.
    function automatic int unsigned cnt_width(input int unsigned max_val);
        return (max_val < 32'd1) ? 32'd1 : $clog2(max_val + 32'd1);
    endfunction

endpackage

// File: rtl/codec_cfg_rom.sv
// Registered lookup table of codec configuration words.
// The table is kept here so it can be edited without touching the FSM.
// Ports:
//   clk    in  system clock, rising edge
//   rst    in  asynchronous active-low reset
//   idx_i  in  table index (captured every cycle)
//   addr_o out 7-bit codec register address of the captured entry
//   data_o out 9-bit codec register data of the captured entry
module codec_cfg_rom
    import codec_cfg_sequencer_pkg::*;
#(
    parameter int unsigned IDX_W = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [IDX_W-1:0] idx_i,
    output logic [6:0]       addr_o,
    output logic [8:0]       data_o
);

    logic [15:0] word_s;
    logic [15:0] word_q;

    // Table contents: {address, data}; unused indices read as zero.
    always_comb begin
        word_s = 16'h0000;
        case (idx_i)
            IDX_W'(0): word_s = {LINVOL, 9'h017};
            IDX_W'(1): word_s = {RINVOL, 9'h017};
            IDX_W'(2): word_s = {LHPOUT, 9'h079};
            IDX_W'(3): word_s = {RHPOUT, 9'h079};
            IDX_W'(4): word_s = {AAPC,   9'h012};
            IDX_W'(5): word_s = {DAPC,   9'h004};
            IDX_W'(6): word_s = {PDC,    9'h002};
            IDX_W'(7): word_s = {DAIF,   9'h042};
            IDX_W'(8): word_s = {SRC,    9'h023};
            IDX_W'(9): word_s = {ACTIVE, 9'h001};
            default:   word_s = 16'h0000;
        endcase
    end

    // Output register of the table.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            word_q <= 16'h0000;
        end else begin
            word_q <= word_s;
        end
    end

    assign addr_o = word_q[15:9];
    assign data_o = word_q[8:0];

endmodule

// File: rtl/codec_cfg_sequencer.sv
// Codec configuration sequencer: walks the configuration table and drives
// the serial register-write engine one word at a time, retrying an entry on
// NACK or timeout and aborting the run once the retries are used up.
// Optional feature macro: CFG_GAP_EN adds a GAP state that idles GAP_CYC
// cycles between consecutive writes.
// Ports:
//   clk      in  system clock, rising edge
//   rst      in  asynchronous active-low reset
//   start    in  run request, sampled only in IDLE
//   busy     out run in progress
//   done     out one-cycle end-of-run pulse (success or abort)
//   err      out run aborted; sticky until the next accepted start
//   step     out index of the entry being written
//   wr_start out one-cycle write request to the engine
//   wr_addr  out codec register address
//   wr_data  out codec register data
//   wr_done  in  write completion pulse
//   wr_nack  in  qualifies wr_done; 1 = not acknowledged
module codec_cfg_sequencer
    import codec_cfg_sequencer_pkg::*;
#(
    parameter int unsigned N_REGS    = DEF_N_REGS,
    parameter int unsigned IDX_W     = 4,
    parameter int unsigned TIMEOUT   = DEF_TIMEOUT,
    parameter int unsigned MAX_RETRY = DEF_MAX_RETRY
`ifdef CFG_GAP_EN
    ,
    parameter int unsigned GAP_CYC   = 64
`endif
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    output logic             busy,
    output logic             done,
    output logic             err,
    output logic [IDX_W-1:0] step,
    output logic             wr_start,
    output logic [6:0]       wr_addr,
    output logic [8:0]       wr_data,
    input  logic             wr_done,
    input  logic             wr_nack
);

    localparam int unsigned TMR_W   = cnt_width(TIMEOUT);
    localparam int unsigned RETRY_W = cnt_width(MAX_RETRY);

    cfg_state_e         state_q, state_d;
    logic [IDX_W-1:0]   idx_q, idx_d;
    logic [RETRY_W-1:0] retry_q, retry_d;
    logic [TMR_W-1:0]   timer_q, timer_d;
    logic               busy_q, busy_d;
    logic               done_q, done_d;
    logic               err_q, err_d;
    logic [IDX_W-1:0]   step_q, step_d;
    logic               wr_start_q, wr_start_d;
    logic [6:0]         wr_addr_q, wr_addr_d;
    logic [8:0]         wr_data_q, wr_data_d;
    logic [6:0]         rom_addr_s;
    logic [8:0]         rom_data_s;
    logic [TMR_W-1:0]   timer_inc_s;
    logic               timeout_s;
`ifdef CFG_GAP_EN
    localparam int unsigned GAP_W = cnt_width(GAP_CYC);
    logic [GAP_W-1:0]   gap_q, gap_d;
`endif

    // The ROM is addressed with the next index so that its registered output
    // is already valid during the LOAD cycle.
    codec_cfg_rom #(
        .IDX_W (IDX_W)
    ) u_rom (
        .clk    (clk),
        .rst    (rst),
        .idx_i  (idx_d),
        .addr_o (rom_addr_s),
        .data_o (rom_data_s)
    );

    // Saturating wait timer; timeout fires in the TIMEOUT-th WAIT cycle.
    always_comb begin
        if (timer_q == TMR_W'(TIMEOUT)) begin
            timer_inc_s = timer_q;
        end else begin
            timer_inc_s = timer_q + TMR_W'(1);
        end
        timeout_s = (timer_inc_s == TMR_W'(TIMEOUT));
    end

    // Next-state and registered-output logic.
    always_comb begin
        state_d    = state_q;
        idx_d      = idx_q;
        retry_d    = retry_q;
        timer_d    = timer_q;
        busy_d     = busy_q;
        done_d     = 1'b0;
        err_d      = err_q;
        step_d     = step_q;
        wr_start_d = 1'b0;
        wr_addr_d  = wr_addr_q;
        wr_data_d  = wr_data_q;
`ifdef CFG_GAP_EN
        gap_d      = gap_q;
`endif
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    state_d = ST_LOAD;
                    idx_d   = {IDX_W{1'b0}};
                    retry_d = {RETRY_W{1'b0}};
                    err_d   = 1'b0;
                    busy_d  = 1'b1;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_LOAD: begin
                // wr_start is raised here so the registered pulse lands in ISSUE.
                state_d    = ST_ISSUE;
                wr_addr_d  = rom_addr_s;
                wr_data_d  = rom_data_s;
                step_d     = idx_q;
                wr_start_d = 1'b1;
            end
            ST_ISSUE: begin
                state_d = ST_WAIT;
                timer_d = {TMR_W{1'b0}};
            end
            ST_WAIT: begin
                timer_d = timer_inc_s;
                // wr_done is tested first so a completion in the timeout cycle wins.
                if (wr_done && !wr_nack) begin
                    state_d = ST_NEXT;
                end else if (wr_done || timeout_s) begin
                    if (retry_q < RETRY_W'(MAX_RETRY)) begin
                        retry_d    = retry_q + RETRY_W'(1);
                        state_d    = ST_ISSUE;
                        wr_start_d = 1'b1;
                    end else begin
                        state_d = ST_FAIL;
                        err_d   = 1'b1;
                        done_d  = 1'b1;
                    end
                end else begin
                    state_d = ST_WAIT;
                end
            end
            ST_NEXT: begin
                if (idx_q == IDX_W'(N_REGS - 32'd1)) begin
                    state_d = ST_FINISH;
                    done_d  = 1'b1;
                end else begin
                    idx_d   = idx_q + IDX_W'(1);
                    retry_d = {RETRY_W{1'b0}};
`ifdef CFG_GAP_EN
                    gap_d   = {GAP_W{1'b0}};
                    state_d = ST_GAP;
`else
                    state_d = ST_LOAD;
`endif
                end
            end
`ifdef CFG_GAP_EN
            ST_GAP: begin
                if (gap_q == GAP_W'(GAP_CYC - 32'd1)) begin
                    state_d = ST_LOAD;
                end else begin
                    gap_d   = gap_q + GAP_W'(1);
                end
            end
`endif
            ST_FINISH: begin
                state_d = ST_IDLE;
                busy_d  = 1'b0;
            end
            ST_FAIL: begin
                state_d = ST_IDLE;
                busy_d  = 1'b0;
            end
            default: begin
                state_d = ST_IDLE;
                busy_d  = 1'b0;
            end
        endcase
    end

    // State, counters and output registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= ST_IDLE;
            idx_q      <= {IDX_W{1'b0}};
            retry_q    <= {RETRY_W{1'b0}};
            timer_q    <= {TMR_W{1'b0}};
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            err_q      <= 1'b0;
            step_q     <= {IDX_W{1'b0}};
            wr_start_q <= 1'b0;
            wr_addr_q  <= 7'h00;
            wr_data_q  <= 9'h000;
        end else begin
            state_q    <= state_d;
            idx_q      <= idx_d;
            retry_q    <= retry_d;
            timer_q    <= timer_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            err_q      <= err_d;
            step_q     <= step_d;
            wr_start_q <= wr_start_d;
            wr_addr_q  <= wr_addr_d;
            wr_data_q  <= wr_data_d;
        end
    end

`ifdef CFG_GAP_EN
    // Inter-write idle counter.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            gap_q <= {GAP_W{1'b0}};
        end else begin
            gap_q <= gap_d;
        end
    end
`endif

    assign busy     = busy_q;
    assign done     = done_q;
    assign err      = err_q;
    assign step     = step_q;
    assign wr_start = wr_start_q;
    assign wr_addr  = wr_addr_q;
    assign wr_data  = wr_data_q;

endmodule

// File: tb/tb_codec_cfg_sequencer.sv
// Self-checking bench for codec_cfg_sequencer (N_REGS=10, TIMEOUT=20,
// MAX_RETRY=2, GAP_CYC=8 when CFG_GAP_EN is defined).
module tb_codec_cfg_sequencer;

    localparam int N   = 10;
    localparam int TMO = 20;
    localparam int MR  = 2;
`ifdef CFG_GAP_EN
    localparam int GAP_EXTRA = 8;
`else
    localparam int GAP_EXTRA = 0;
`endif
    localparam int O_ACK = 0;
    localparam int O_NAK = 1;
    localparam int O_SIL = 2;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       start = 1'b0;
    logic       wr_done = 1'b0;
    logic       wr_nack = 1'b0;
    logic       busy, done, err, wr_start;
    logic [3:0] step;
    logic [6:0] wr_addr;
    logic [8:0] wr_data;

    always #5 clk = ~clk;

    codec_cfg_sequencer #(
        .N_REGS    (10),
        .IDX_W     (4),
        .TIMEOUT   (20),
        .MAX_RETRY (2)
`ifdef CFG_GAP_EN
        ,
        .GAP_CYC   (8)
`endif
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .start    (start),
        .busy     (busy),
        .done     (done),
        .err      (err),
        .step     (step),
        .wr_start (wr_start),
        .wr_addr  (wr_addr),
        .wr_data  (wr_data),
        .wr_done  (wr_done),
        .wr_nack  (wr_nack)
    );

    // Expected configuration table (codec register map order).
    logic [6:0] ref_addr [N];
    logic [8:0] ref_data [N];

    // Engine behaviour per (entry, attempt).
    int outcome [N][MR+1];
    int delay   [N][MR+1];
    int att     [N];

    typedef struct {
        int         cyc;
        logic [6:0] a;
        logic [8:0] d;
        logic [3:0] s;
    } pulse_t;
    pulse_t pq[$];

    int         cyc = 0;
    int         done_cnt, done_cyc, busy_cnt, unstable;
    logic       done_err;
    logic [3:0] done_step;
    bit         flight;
    logic [6:0] fl_a;
    logic [8:0] fl_d;

    int tests = 0;
    int fails = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input int act, input int exp);
        tests++;
        if (act != exp) begin
            fails++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    // Monitor: records wr_start pulses, done pulses, busy cycles, stability.
    initial begin
        forever begin
            @(negedge clk);
            if (wr_start) begin
                pq.push_back('{cyc, wr_addr, wr_data, step});
                flight = 1'b1;
                fl_a   = wr_addr;
                fl_d   = wr_data;
            end else if (flight) begin
                if (wr_addr !== fl_a || wr_data !== fl_d) unstable++;
                if (wr_done) flight = 1'b0;
            end
            if (done) begin
                done_cnt++;
                done_cyc  = cyc;
                done_err  = err;
                done_step = step;
                flight    = 1'b0;
            end
            if (busy) busy_cnt++;
        end
    end

    // Write-engine responder.
    initial begin
        int e, a;
        forever begin
            @(negedge clk);
            if (wr_start) begin
                e = int'(wr_addr);
                if (e >= N) e = 0;
                a = att[e];
                if (a > MR) a = MR;
                att[e]++;
                if (outcome[e][a] != O_SIL) begin
                    repeat (delay[e][a]) @(posedge clk);
                    #1;
                    wr_done = 1'b1;
                    wr_nack = (outcome[e][a] == O_NAK);
                    @(posedge clk);
                    #1;
                    wr_done = 1'b0;
                    wr_nack = 1'b0;
                end
            end
        end
    end

    task automatic clear_mon();
        pq.delete();
        done_cnt = 0;
        busy_cnt = 0;
        unstable = 0;
        flight   = 1'b0;
        for (int e = 0; e < N; e++) att[e] = 0;
    endtask

    task automatic set_plan(input int mode, input int fent, input int fcnt, input int dly);
        for (int e = 0; e < N; e++)
            for (int a = 0; a <= MR; a++) begin
                outcome[e][a] = (e == fent && a < fcnt) ? mode : O_ACK;
                delay[e][a]   = dly;
            end
    endtask

    // One full run: optional stray wr_done in IDLE and second start while busy.
    task automatic run_check(input string tag, input bit poke, output int n_pulses, output int got_err);
        int s, t, fin, e_step, e_done;
        bit ok, failed, e_err;
        int exp_e[$];
        int exp_t[$];
        clear_mon();
        if (poke) begin
            @(posedge clk); #1;
            wr_done = 1'b1;
            @(posedge clk); #1;
            wr_done = 1'b0;
            repeat (3) @(negedge clk);
            chk({tag, "_stray_done"}, pq.size() + busy_cnt + done_cnt, 0);
        end
        @(posedge clk); #1;
        start = 1'b1;
        s = cyc;
        @(posedge clk); #1;
        start = 1'b0;
        @(negedge clk);
        chk({tag, "_busy_err_after_start"}, {30'd0, busy, err}, 2);
        if (poke) begin
            repeat (4) @(posedge clk);
            #1;
            start = 1'b1;
            @(posedge clk); #1;
            start = 1'b0;
        end
        for (int k = 0; k < 5000 && done_cnt == 0; k++) @(negedge clk);
        chk({tag, "_done_seen"}, done_cnt > 0, 1);
        repeat (4) @(negedge clk);

        // Reference: entries issued attempt by attempt with spec latencies.
        t = s + 2; fin = 0; failed = 0; e_err = 0; e_step = N - 1;
        for (int e = 0; e < N && !failed; e++) begin
            ok = 0;
            for (int a = 0; a <= MR && !ok; a++) begin
                exp_e.push_back(e);
                exp_t.push_back(t);
                if (outcome[e][a] == O_ACK) begin
                    ok = 1; fin = t + delay[e][a]; t = fin + 3 + GAP_EXTRA;
                end else if (outcome[e][a] == O_NAK) begin
                    fin = t + delay[e][a]; t = fin + 1;
                end else begin
                    fin = t + TMO; t = fin + 1;
                end
            end
            if (!ok) begin failed = 1; e_err = 1; e_step = e; end
        end
        e_done = failed ? fin + 1 : fin + 2;

        chk({tag, "_n_pulses"}, pq.size(), exp_e.size());
        for (int i = 0; i < pq.size() && i < exp_e.size(); i++) begin
            chk($sformatf("%s_p%0d_addr", tag, i), int'(pq[i].a), int'(ref_addr[exp_e[i]]));
            chk($sformatf("%s_p%0d_data", tag, i), int'(pq[i].d), int'(ref_data[exp_e[i]]));
            chk($sformatf("%s_p%0d_step", tag, i), int'(pq[i].s), exp_e[i]);
            chk($sformatf("%s_p%0d_cycle", tag, i), pq[i].cyc - s, exp_t[i] - s);
        end
        chk({tag, "_done_count"}, done_cnt, 1);
        chk({tag, "_done_cycle"}, done_cyc - s, e_done - s);
        chk({tag, "_err_at_done"}, int'(done_err), int'(e_err));
        chk({tag, "_step_at_done"}, int'(done_step), e_step);
        chk({tag, "_busy_cycles"}, busy_cnt, e_done - s);
        chk({tag, "_addr_stable"}, unstable, 0);
        chk({tag, "_idle_after"}, {30'd0, busy, err}, int'(e_err));
        n_pulses = pq.size();
        got_err  = int'(done_err);
    endtask

    typedef struct {
        int mode; int fent; int fcnt; int dly; bit poke;
        int exp_pulses; int exp_err; int exp_step;
    } vec_t;
    vec_t vt[8];

    initial begin
        int np, ge;
        ref_addr = '{7'h00, 7'h01, 7'h02, 7'h03, 7'h04, 7'h05, 7'h06, 7'h07, 7'h08, 7'h09};
        ref_data = '{9'h017, 9'h017, 9'h079, 9'h079, 9'h012, 9'h004, 9'h002, 9'h042, 9'h023, 9'h001};
        vt[0] = '{O_ACK, 0, 0, 5,  1'b0, 10, 0, 9};
        vt[1] = '{O_NAK, 3, 1, 5,  1'b0, 11, 0, 9};
        vt[2] = '{O_SIL, 0, 3, 5,  1'b0, 3,  1, 0};
        vt[3] = '{O_NAK, 9, 3, 7,  1'b0, 12, 1, 9};
        vt[4] = '{O_NAK, 0, 2, 4,  1'b1, 12, 0, 9};
        vt[5] = '{O_ACK, 0, 0, 20, 1'b0, 10, 0, 9};
        vt[6] = '{O_ACK, 0, 0, 1,  1'b0, 10, 0, 9};
        vt[7] = '{O_SIL, 4, 2, 3,  1'b0, 12, 0, 9};
        set_plan(O_ACK, 0, 0, 5);
        clear_mon();

        repeat (10) @(negedge clk);
        chk("reset_outputs", int'({busy, done, err, step, wr_start, wr_addr, wr_data}), 0);
        rst = 1'b1;
        repeat (2) @(negedge clk);

        for (int i = 0; i < 8; i++) begin
            set_plan(vt[i].mode, vt[i].fent, vt[i].fcnt, vt[i].dly);
            run_check($sformatf("vec%0d", i), vt[i].poke, np, ge);
            chk($sformatf("vec%0d_table_pulses", i), np, vt[i].exp_pulses);
            chk($sformatf("vec%0d_table_err", i), ge, vt[i].exp_err);
            chk($sformatf("vec%0d_table_step", i), int'(done_step), vt[i].exp_step);
        end

        // Reset during WAIT of entry 5, following an aborted run.
        set_plan(O_SIL, 0, 3, 5);
        run_check("pre_rst_fail", 1'b0, np, ge);
        set_plan(O_ACK, 0, 0, 5);
        clear_mon();
        @(posedge clk); #1;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        for (int k = 0; k < 2000 && pq.size() < 6; k++) @(negedge clk);
        chk("rst_reached_entry5", pq.size(), 6);
        repeat (2) @(negedge clk);
        rst = 1'b0;
        #1;
        chk("rst_async_outputs", int'({busy, done, err, step, wr_start, wr_addr, wr_data}), 0);
        repeat (3) @(negedge clk);
        rst = 1'b1;
        repeat (10) @(negedge clk);
        chk("rst_no_done_no_busy", done_cnt + int'(busy), 0);
        run_check("post_rst", 1'b0, np, ge);

        // Randomised engine behaviour against the reference.
        for (int r = 0; r < 6; r++) begin
            for (int e = 0; e < N; e++)
                for (int a = 0; a <= MR; a++) begin
                    int x;
                    x = int'($urandom_range(99));
                    outcome[e][a] = (x < 78) ? O_ACK : ((x < 90) ? O_NAK : O_SIL);
                    delay[e][a]   = int'($urandom_range(20, 1));
                end
            run_check($sformatf("rand%0d", r), 1'b0, np, ge);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached, %0d failed so far", fails);
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/codec_cfg_sequencer.md
Name: codec_cfg_sequencer

Overview:
Steps through a fixed table of codec configuration words and drives the serial register-write engine one word at a time. It waits for each write's completion, and retries or aborts on a NACK or a timeout. Sits between MAIN_CONTROL and the write engine: MAIN_CONTROL pulses start after reset or a config command, and this block owns the write engine's start/done handshake until the table is finished.

Parameters:
N_REGS, 10, number of table entries issued per run (1..16)
IDX_W, 4, width of the table index
TIMEOUT, 1023, max cycles to wait in WAIT for wr_done before a timeout
MAX_RETRY, 2, extra attempts per entry after a NACK or timeout
GAP_CYC, 64, inter-write idle cycles; used only with CFG_GAP_EN

Ports:
clk  in  1  system clock, rising edge
rst  in  1  asynchronous, active-low reset
start  in  1  one-cycle request to run the table; sampled only in IDLE
busy  out  1  high from the cycle after start is accepted until done
done  out  1  one-cycle pulse at the end of a run (success or fail)
err  out  1  run aborted; sticky until the next accepted start
step  out  IDX_W  index of the entry currently being written
wr_start  out  1  one-cycle pulse to the write engine
wr_addr  out  7  codec register address
wr_data  out  9  codec register data
wr_done  in  1  one-cycle completion pulse from the write engine
wr_nack  in  1  valid with wr_done; 1 = slave did not acknowledge

Behaviour:
- All outputs are registered. Reset values: busy=0, done=0, err=0, step=0, wr_start=0, wr_addr=0, wr_data=0; FSM in IDLE, retry and timer counters at 0.
- Reset asserted mid-run: everything returns to reset values immediately; no done pulse; the write engine is not notified.
- States: IDLE, LOAD, ISSUE, WAIT, GAP (feature only), NEXT, FINISH, FAIL.
- IDLE: on start=1, go to LOAD with idx=0 and retry=0; clear err; busy=1 from the next cycle. start is ignored in every other state.
- LOAD: read rom[idx] (registered ROM, 1 cycle). Latch wr_addr/wr_data; step=idx.
- ISSUE: wr_start=1 for exactly one cycle; clear the timer; go to WAIT. Latency from accepted start to the first wr_start is 2 cycles.
- WAIT: the timer increments each cycle. wr_addr/wr_data stay stable from LOAD until WAIT is left.
  - wr_done=1 and wr_nack=0 -> NEXT.
  - wr_done=1 and wr_nack=1, or timer reaches TIMEOUT -> failure case:
    - if retry<MAX_RETRY: retry+1, then ISSUE (the same word is re-sent);
    - otherwise go to FAIL.
  - wr_done in the same cycle as the timeout: wr_done wins.
- wr_done or wr_nack outside WAIT: ignored.
- NEXT:
  - if idx==N_REGS-1, go to FINISH;
  - otherwise idx+1 and retry=0, then LOAD (or GAP with the feature enabled).
- FINISH: done=1 for one cycle, busy=0 on the following cycle, err stays 0; return to IDLE.
- FAIL: err=1 and done=1 in the same cycle, busy=0 next; step holds the failing index; return to IDLE.
- A start accepted after FAIL clears err and restarts from index 0.
- Timer width is ceil(log2(TIMEOUT+1)); it saturates and never wraps.

Optional Feature:
CFG_GAP_EN:
- Defined: NEXT goes to GAP, which counts GAP_CYC cycles with all outputs held, then LOAD. This meets the codec's minimum bus-idle time between writes.
- Undefined: the GAP state and its counter are not compiled; NEXT goes directly to LOAD.

Decomposition:
- Shared package/include: state encodings; codec address constants (LINVOL, RINVOL, LHPOUT, RHPOUT, AAPC, DAPC, PDC, DAIF, SRC, ACTIVE); default TIMEOUT and MAX_RETRY.
- One sub-module, codec_cfg_rom: registered IDX_W-in, 16-out lookup (7-bit address + 9-bit data). Kept separate so the table can be edited without touching the FSM.

Test Plan:
- Reset low for 10 cycles, then start pulse with N_REGS=10 and the engine answering wr_done 5 cycles after each wr_start (nack=0) -> 10 wr_start pulses, addresses in ROM order, first wr_start 2 cycles after start; one done pulse; err=0; busy low the cycle after done.
- NACK on entry 3, first attempt only -> entry 3 issued twice with identical wr_addr/wr_data; run completes with err=0.
- Engine never answers, TIMEOUT=20, MAX_RETRY=2 -> 3 wr_start pulses for entry 0, each 21 cycles apart; then done=1 with err=1, step=0.
- Second start pulse while busy, plus a stray wr_done in IDLE -> both ignored; sequence and pulse counts unchanged.
- rst driven low during WAIT of entry 5 -> all outputs 0 asynchronously; a new start restarts at step 0; err cleared.
- CFG_GAP_EN defined, GAP_CYC=8 -> at least 8 idle cycles between each wr_done and the next wr_start; success path otherwise identical.
